regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 24 ++
 rtl/regfile_wb_arbiter_regsel.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file write-back arbiter.
//   DATA_W   : default write-back data width
//   NUM_REGS : default register count (width of the one-hot write select)
//   ZERO_REG : index of the hard-wired zero register, never written
//   RD_W     : width of a register index
//   grant_e  : requester encoding used for the round-robin last-grant bit
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;
    localparam int RD_W     = 5;

    // GNT_ALU must stay 0 so that a cleared last-grant bit means "ALU won
    // last", which hands the first conflict after reset to the load path.
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_regsel.sv
// ---------------------------------------------------------------------------
// regsel_decoder
// Turns the pending destination index into the one-hot register-file write
// enable. The zero register is masked so it can never be written.
// Ports:
//   i_valid : a write is pending
//   i_rd    : destination register index
//   o_sel   : one-hot write enable (all zeros when idle or when rd is zero reg)
// ---------------------------------------------------------------------------
module regsel_decoder #(
    parameter int NUM_REGS = regfile_wb_arbiter_pkg::NUM_REGS,
    parameter int ZERO_REG = regfile_wb_arbiter_pkg::ZERO_REG
) (
    input  logic                                   i_valid,
    input  logic [regfile_wb_arbiter_pkg::RD_W-1:0] i_rd,
    output logic [NUM_REGS-1:0]                    o_sel
);

    import regfile_wb_arbiter_pkg::*;

    // Each select bit compares the index against its own position, so the
    // output is one-hot by construction and the zero register bit is forced low.
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_sel[i] = i_valid && (i_rd == RD_W'(i)) && (i != ZERO_REG);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges the ALU and load write-back streams into a single register-file
// write port through one output register (1-cycle latency). Conflicts are
// resolved round-robin; the register file can freeze the output with wr_hold.
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   alu_valid/rd/data/ready   : ALU write-back requester (valid/ready)
//   mem_valid/rd/data/ready   : load write-back requester (valid/ready)
//   wr_hold                   : register file busy, freeze the output stage
//   dselect                   : one-hot write enable to the register file
//   dbus                      : write data to the register file
//   rs_a/rs_b, busy_a/busy_b  : hazard query against the pending write
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W   = regfile_wb_arbiter_pkg::DATA_W,
    parameter int NUM_REGS = regfile_wb_arbiter_pkg::NUM_REGS,
    parameter int ZERO_REG = regfile_wb_arbiter_pkg::ZERO_REG
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   alu_valid,
    input  logic [regfile_wb_arbiter_pkg::RD_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]                      alu_data,
    output logic                                   alu_ready,
    input  logic                                   mem_valid,
    input  logic [regfile_wb_arbiter_pkg::RD_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]                      mem_data,
    output logic                                   mem_ready,
    input  logic                                   wr_hold,
    output logic [NUM_REGS-1:0]                    dselect,
    output logic [DATA_W-1:0]                      dbus,
    input  logic [regfile_wb_arbiter_pkg::RD_W-1:0] rs_a,
    input  logic [regfile_wb_arbiter_pkg::RD_W-1:0] rs_b,
    output logic                                   busy_a,
    output logic                                   busy_b
);

    import regfile_wb_arbiter_pkg::*;

    localparam logic [RD_W-1:0] ZERO_RD = RD_W'(ZERO_REG);

    logic              r_outValid;
    logic [RD_W-1:0]   r_outRd;
    logic [DATA_W-1:0] r_outData;
    grant_e            r_lastGrant;

    logic              w_aluReady;
    logic              w_memReady;
    logic              w_pendingWrite;
    logic [NUM_REGS-1:0] w_sel;

    // Grant logic. Nothing is granted while reset is low or the register file
    // holds the output. A lone requester always wins; on a conflict the side
    // that did not win last time gets the slot, so neither can starve.
    always_comb begin
        w_aluReady = 1'b0;
        w_memReady = 1'b0;
        if (reset_n && !wr_hold) begin
            if (alu_valid && mem_valid) begin
                if (r_lastGrant == GNT_ALU) begin
                    w_memReady = 1'b1;
                end else begin
                    w_aluReady = 1'b1;
                end
            end else begin
                w_aluReady = alu_valid;
                w_memReady = mem_valid;
            end
        end
    end

    assign alu_ready = w_aluReady;
    assign mem_ready = w_memReady;

    // Output register. A transfer loads the winner's rd/data and records who
    // won; with no transfer the entry retires after one cycle. During wr_hold
    // everything, including the last-grant bit, is frozen. Reset discards any
    // pending entry so no write escapes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_outValid  <= 1'b0;
            r_outRd     <= '0;
            r_outData   <= '0;
            r_lastGrant <= GNT_ALU;
        end else if (!wr_hold) begin
            if (w_aluReady) begin
                r_outValid  <= 1'b1;
                r_outRd     <= alu_rd;
                r_outData   <= alu_data;
                r_lastGrant <= GNT_ALU;
            end else if (w_memReady) begin
                r_outValid  <= 1'b1;
                r_outRd     <= mem_rd;
                r_outData   <= mem_data;
                r_lastGrant <= GNT_MEM;
            end else begin
                r_outValid  <= 1'b0;
            end
        end
    end

    regsel_decoder #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_regsel (
        .i_valid (r_outValid),
        .i_rd    (r_outRd),
        .o_sel   (w_sel)
    );

    assign dselect = w_sel;
    assign dbus    = r_outValid ? r_outData : '0;

    // A write to the zero register never lands, so it cannot create a hazard.
    assign w_pendingWrite = r_outValid && (r_outRd != ZERO_RD);
    assign busy_a         = w_pendingWrite && (r_outRd == rs_a);
    assign busy_b         = w_pendingWrite && (r_outRd == rs_b);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter: a directed vector table, then
// randomized traffic compared against a behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    typedef struct {
        logic        rstN;
        logic        hold;
        logic        aV;
        logic [4:0]  aRd;
        logic [63:0] aD;
        logic        mV;
        logic [4:0]  mRd;
        logic [63:0] mD;
        logic [4:0]  rsA;
        logic [4:0]  rsB;
    } in_t;

    typedef struct {
        logic        aR;
        logic        mR;
        logic [31:0] sel;
        logic [63:0] bus;
        logic        bA;
        logic        bB;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        mem_ready;
    logic        wr_hold;
    logic [31:0] dselect;
    logic [63:0] dbus;
    logic [4:0]  rs_a;
    logic [4:0]  rs_b;
    logic        busy_a;
    logic        busy_b;

    int nChecks = 0;
    int nPass   = 0;

    vec_t tbl[$];

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wr_hold   (wr_hold),
        .dselect   (dselect),
        .dbus      (dbus),
        .rs_a      (rs_a),
        .rs_b      (rs_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

    function automatic vec_t mkVec(
        logic rstN, logic hold, logic aV, logic [4:0] aRd, logic [63:0] aD,
        logic mV, logic [4:0] mRd, logic [63:0] mD, logic [4:0] rsA, logic [4:0] rsB,
        logic eAR, logic eMR, logic [31:0] eSel, logic [63:0] eBus, logic eBA, logic eBB);
        vec_t v;
        v.in.rstN = rstN; v.in.hold = hold;
        v.in.aV = aV; v.in.aRd = aRd; v.in.aD = aD;
        v.in.mV = mV; v.in.mRd = mRd; v.in.mD = mD;
        v.in.rsA = rsA; v.in.rsB = rsB;
        v.exp.aR = eAR; v.exp.mR = eMR; v.exp.sel = eSel;
        v.exp.bus = eBus; v.exp.bA = eBA; v.exp.bB = eBB;
        return v;
    endfunction

    task automatic applyStimulus(input in_t s);
        reset_n   = s.rstN;
        wr_hold   = s.hold;
        alu_valid = s.aV;
        alu_rd    = s.aRd;
        alu_data  = s.aD;
        mem_valid = s.mV;
        mem_rd    = s.mRd;
        mem_data  = s.mD;
        rs_a      = s.rsA;
        rs_b      = s.rsB;
    endtask

    task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input out_t e);
        checkField({tag, ".alu_ready"}, 64'(alu_ready), 64'(e.aR));
        checkField({tag, ".mem_ready"}, 64'(mem_ready), 64'(e.mR));
        checkField({tag, ".dselect"},   64'(dselect),   64'(e.sel));
        checkField({tag, ".dbus"},      dbus,           e.bus);
        checkField({tag, ".busy_a"},    64'(busy_a),    64'(e.bA));
        checkField({tag, ".busy_b"},    64'(busy_b),    64'(e.bB));
    endtask

    // Apply one cycle of inputs at the falling edge, check just after, then
    // let the rising edge consume them.
    task automatic runCycle(input string tag, input in_t s, input out_t e);
        applyStimulus(s);
        #1;
        checkOutput(tag, e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed table, then randomized traffic against the reference model.
    initial begin
        in_t  s;
        out_t e;
        logic mLast;
        logic mValid;
        logic [4:0] mRd;
        logic [63:0] mData;
        logic gA;
        logic gM;
        int aWait;
        int mWait;

        // Rows: inputs | expected ready/select/bus/busy during that cycle.
        tbl.push_back(mkVec(1,0, 1,5,64'hDEAD, 0,0,0,     5,0,  1,0,32'h0,    64'h0,    0,0));
        tbl.push_back(mkVec(1,0, 0,0,0,        0,0,0,     5,0,  0,0,32'h20,   64'hDEAD, 1,0));
        tbl.push_back(mkVec(1,0, 1,1,64'h11,   1,2,64'h22,1,2,  0,1,32'h0,    64'h0,    0,0));
        tbl.push_back(mkVec(1,0, 1,1,64'h11,   1,2,64'h22,1,2,  1,0,32'h4,    64'h22,   0,1));
        tbl.push_back(mkVec(1,0, 1,1,64'h11,   1,2,64'h22,1,2,  0,1,32'h2,    64'h11,   1,0));
        tbl.push_back(mkVec(1,0, 1,1,64'h11,   1,2,64'h22,1,2,  1,0,32'h4,    64'h22,   0,1));
        tbl.push_back(mkVec(1,0, 0,0,0,        1,31,64'hFFFF,31,1, 0,1,32'h2, 64'h11,   0,1));
        tbl.push_back(mkVec(1,0, 1,7,64'h77,   0,0,0,     31,0, 1,0,32'h0,    64'hFFFF, 0,0));
        tbl.push_back(mkVec(1,1, 1,9,64'h99,   0,0,0,     7,9,  0,0,32'h80,   64'h77,   1,0));
        tbl.push_back(mkVec(1,1, 1,9,64'h99,   0,0,0,     7,9,  0,0,32'h80,   64'h77,   1,0));
        tbl.push_back(mkVec(1,1, 1,9,64'h99,   0,0,0,     7,9,  0,0,32'h80,   64'h77,   1,0));
        tbl.push_back(mkVec(1,0, 1,9,64'h99,   0,0,0,     7,9,  1,0,32'h80,   64'h77,   1,0));
        tbl.push_back(mkVec(1,0, 0,0,0,        1,3,64'h33,9,3,  0,1,32'h200,  64'h99,   1,0));
        tbl.push_back(mkVec(0,0, 1,4,64'h44,   1,6,64'h66,3,3,  0,0,32'h8,    64'h33,   1,1));
        tbl.push_back(mkVec(1,0, 1,4,64'h44,   1,6,64'h66,3,6,  0,1,32'h0,    64'h0,    0,0));
        tbl.push_back(mkVec(1,0, 1,4,64'h44,   1,8,64'h88,6,4,  1,0,32'h40,   64'h66,   1,0));
        tbl.push_back(mkVec(1,0, 0,0,0,        0,0,0,     0,4,  0,0,32'h10,   64'h44,   0,1));
        tbl.push_back(mkVec(1,0, 0,0,0,        0,0,0,     0,4,  0,0,32'h0,    64'h0,    0,0));

        // Reset with both requesters knocking: readies stay low and the
        // write port reads idle once reset has been sampled.
        s = '{rstN:0, hold:0, aV:1, aRd:5'd4, aD:64'h1, mV:1, mRd:5'd6, mD:64'h2, rsA:5'd0, rsB:5'd0};
        applyStimulus(s);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        e = '{aR:0, mR:0, sel:32'h0, bus:64'h0, bA:0, bB:0};
        checkOutput("reset", e);
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            runCycle($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
        end

        // Fresh reset so the model starts from a known state.
        s = '{rstN:0, hold:0, aV:0, aRd:5'd0, aD:64'h0, mV:0, mRd:5'd0, mD:64'h0, rsA:5'd0, rsB:5'd0};
        applyStimulus(s);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        mLast  = 1'b0;
        mValid = 1'b0;
        mRd    = '0;
        mData  = '0;
        gA     = 1'b0;
        gM     = 1'b0;
        aWait  = 0;
        mWait  = 0;

        for (int c = 0; c < 400; c++) begin
            // A requester keeps its rd/data until it is accepted.
            if (!s.aV || gA) begin
                s.aV  = ($urandom_range(0, 99) < 65);
                s.aRd = 5'($urandom);
                s.aD  = {$urandom, $urandom};
            end
            if (!s.mV || gM) begin
                s.mV  = ($urandom_range(0, 99) < 65);
                s.mRd = 5'($urandom);
                s.mD  = {$urandom, $urandom};
            end
            s.rstN = ($urandom_range(0, 99) >= 3);
            s.hold = ($urandom_range(0, 99) < 20);
            s.rsA  = ($urandom_range(0, 2) == 0) ? mRd : 5'($urandom);
            s.rsB  = ($urandom_range(0, 2) == 0) ? mRd : 5'($urandom);

            // Who may transfer this cycle: nobody in reset or hold, a lone
            // requester always, and on a conflict whoever did not win last.
            gA = 1'b0;
            gM = 1'b0;
            if (s.rstN && !s.hold) begin
                if (s.aV && s.mV) begin
                    gA = mLast;
                    gM = !mLast;
                end else begin
                    gA = s.aV;
                    gM = s.mV;
                end
            end

            e.aR  = gA;
            e.mR  = gM;
            e.sel = (mValid && mRd != 5'd31) ? (32'd1 << mRd) : 32'd0;
            e.bus = mValid ? mData : 64'd0;
            e.bA  = mValid && mRd != 5'd31 && mRd == s.rsA;
            e.bB  = mValid && mRd != 5'd31 && mRd == s.rsB;

            applyStimulus(s);
            #1;
            checkOutput("rand", e);

            // Starvation bound: a waiting requester loses at most one
            // non-hold cycle before it is accepted.
            if (!s.rstN) begin
                aWait = 0;
                mWait = 0;
            end else begin
                if (gA) begin
                    checkField("alu_starve", 64'(aWait <= 1), 64'd1);
                    aWait = 0;
                end else if (s.aV && !s.hold) begin
                    aWait++;
                end
                if (gM) begin
                    checkField("mem_starve", 64'(mWait <= 1), 64'd1);
                    mWait = 0;
                end else if (s.mV && !s.hold) begin
                    mWait++;
                end
            end

            @(posedge clk);
            if (!s.rstN) begin
                mValid = 1'b0;
                mRd    = '0;
                mData  = '0;
                mLast  = 1'b0;
            end else if (!s.hold) begin
                if (gA) begin
                    mValid = 1'b1;
                    mRd    = s.aRd;
                    mData  = s.aD;
                    mLast  = 1'b0;
                end else if (gM) begin
                    mValid = 1'b1;
                    mRd    = s.mRd;
                    mData  = s.mD;
                    mLast  = 1'b1;
                end else begin
                    mValid = 1'b0;
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
